// File: rtl/oka_mult_seq_if.sv
// Valid/ready operand and result bus for the sequential OKA carry-less multiplier.
// The master side supplies operands and accepts results; the multiplier is the slave.
interface oka_mult_seq_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-2:0] y;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/oka_mult_seq.sv
// Time-multiplexed overlap-free Karatsuba carry-less multiplier: one even/odd split,
// one shared N/2-bit core, optional bit-serial reduction mod x^N+POLY.
module oka_mult_seq #(
    parameter int           N      = 32,
    parameter int           REDUCE = 0,
    parameter logic [N-1:0] POLY   = N'(32'h0000_008D)
) (
    input  logic             clk,
    input  logic             rst_n,
    oka_mult_seq_if.slave    bus,
    output logic             busy
);
    localparam int H  = N / 2;
    localparam int W  = 2 * N - 1;
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {IDLE, S_P0, S_P1, S_P2, RED, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [N-2:0]    p0_q, p0_d, p1_q, p1_d;
    logic [W-1:0]    r_q, r_d, y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;

    logic [H-1:0]    a_e, a_o, b_e, b_o;
    logic [H-1:0]    core_x, core_y;
    logic [N-2:0]    core_p;
    logic [N-2:0]    mid;
    logic [W-1:0]    y_full, r_red, poly_ext;
    logic [CW-1:0]   shamt;

    function automatic logic [W-1:0] spr(input logic [N-2:0] p);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < N - 1; i++) s[2*i] = p[i];
        return s;
    endfunction

    always_comb begin
        a_e = '0;
        a_o = '0;
        b_e = '0;
        b_o = '0;
        for (int i = 0; i < H; i++) begin
            a_e[i] = a_q[2*i];
            a_o[i] = a_q[2*i+1];
            b_e[i] = b_q[2*i];
            b_o[i] = b_q[2*i+1];
        end
    end

    // Shared core: operands chosen by the current phase, P2 operands otherwise.
    always_comb begin
        core_x = a_e ^ a_o;
        core_y = b_e ^ b_o;
        if (state_q == S_P0) begin
            core_x = a_e;
            core_y = b_e;
        end else if (state_q == S_P1) begin
            core_x = a_o;
            core_y = b_o;
        end
        core_p = '0;
        for (int i = 0; i < H; i++) begin
            if (core_x[i]) core_p = core_p ^ ({{(N-1-H){1'b0}}, core_y} << i);
        end
    end

    always_comb begin
        mid    = p0_q ^ p1_q ^ core_p;
        y_full = spr(p0_q) ^ (spr(mid) << 1) ^ (spr(p1_q) << 2);
    end

    // One reduction step folds x^cnt back onto x^(cnt-N) * POLY.
    always_comb begin
        poly_ext = {{(N-1){1'b0}}, POLY};
        shamt    = cnt_q - CW'(N);
        r_red    = r_q;
        if (r_q[cnt_q]) begin
            r_red        = r_q ^ (poly_ext << shamt);
            r_red[cnt_q] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        r_d         = r_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_P0;
                end
            end
            S_P0: begin
                p0_d    = core_p;
                state_d = S_P1;
            end
            S_P1: begin
                p1_d    = core_p;
                state_d = S_P2;
            end
            S_P2: begin
                r_d = y_full;
                if (REDUCE != 0) begin
                    cnt_d   = CW'(W - 1);
                    state_d = RED;
                end else begin
                    y_d         = y_full;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            RED: begin
                r_d   = r_red;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(N)) begin
                    y_d         = {{(N-1){1'b0}}, r_red[N-1:0]};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            r_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            r_q         <= r_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_oka_mult_seq.sv
// Directed and random bench for oka_mult_seq: three instances (N=32 plain, N=32 reduced,
// N=8 reduced) checked against a bitwise clmul/modular-reduction reference via a scoreboard.
module tb_oka_mult_seq;
    logic clk;
    logic rst_n;
    logic busy0, busy1, busy2;

    int n_assert;
    int n_fail;
    logic [62:0] sb[$];
    logic [62:0] discard;

    oka_mult_seq_if #(.N(32)) if0 ();
    oka_mult_seq_if #(.N(32)) if1 ();
    oka_mult_seq_if #(.N(8))  if2 ();

    oka_mult_seq #(.N(32), .REDUCE(0), .POLY(32'h0000_008D)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0));
    oka_mult_seq #(.N(32), .REDUCE(1), .POLY(32'h0000_008D)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));
    oka_mult_seq #(.N(8), .REDUCE(1), .POLY(8'h1B)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: schoolbook carry-less product, then long division by x^n + poly.
    function automatic logic [62:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input int n, input int red, input logic [31:0] poly);
        logic [62:0] p;
        logic [62:0] f;
        p = '0;
        for (int i = 0; i < n; i++) if (a[i]) p = p ^ (63'(b) << i);
        if (red != 0) begin
            f = (63'(1) << n) | 63'(poly);
            for (int k = 2 * n - 2; k >= n; k--) if (p[k]) p = p ^ (f << (k - n));
        end
        return p;
    endfunction

    function automatic logic getOv(input int d);
        case (d)
            0: return if0.out_valid;
            1: return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic getIr(input int d);
        case (d)
            0: return if0.in_ready;
            1: return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic getBusy(input int d);
        case (d)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [62:0] getY(input int d);
        case (d)
            0: return if0.y;
            1: return if1.y;
            default: return 63'(if2.y);
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] b);
        case (d)
            0: begin if0.in_valid = v; if0.a = a; if0.b = b; end
            1: begin if1.in_valid = v; if1.a = a; if1.b = b; end
            default: begin if2.in_valid = v; if2.a = a[7:0]; if2.b = b[7:0]; end
        endcase
    endtask

    task automatic setOready(input int d, input logic v);
        case (d)
            0: if0.out_ready = v;
            1: if1.out_ready = v;
            default: if2.out_ready = v;
        endcase
    endtask

    task automatic check(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair for exactly one accept edge and queues its expected result.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] b,
                                 input int n, input int red, input logic [31:0] poly);
        check("accept_in_ready", 63'(getIr(d)), 63'(1));
        drive(d, 1'b1, a, b);
        sb.push_back(refMul(a, b, n, red, poly));
        tick();
        drive(d, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic waitValid(input int d, output int lat);
        lat = 0;
        while (!getOv(d) && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic checkOutput(input int d, input int expLat, input string tag);
        int lat;
        waitValid(d, lat);
        check({tag, "_valid"}, 63'(getOv(d)), 63'(1));
        if (expLat >= 0) check({tag, "_latency"}, 63'(lat), 63'(expLat));
        check(tag, getY(d), sb.pop_front());
        setOready(d, 1'b1);
        tick();
        setOready(d, 1'b0);
        check({tag, "_drop"}, 63'(getOv(d)), 63'(0));
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb, mask;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 32'h0, 32'h0);
            setOready(d, 1'b0);
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check("reset_in_ready", 63'(getIr(d)), 63'(1));
            check("reset_out_valid", 63'(getOv(d)), 63'(0));
            check("reset_busy", 63'(getBusy(d)), 63'(0));
            check("reset_y", getY(d), 63'(0));
        end
        rst_n = 1'b1;
        tick();

        applyStimulus(0, 32'h1, 32'h1, 32, 0, 32'h0);
        check("busy_running", 63'(getBusy(0)), 63'(1));
        checkOutput(0, 3, "one_x_one");
        tick();
        applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0, 32'h0);
        checkOutput(0, 3, "all_ones");
        check("all_ones_const", u0.y_q, 63'h5555_5555_5555_5555);
        tick();
        applyStimulus(0, 32'h8000_0000, 32'h2, 32, 0, 32'h0);
        checkOutput(0, 3, "top_bit");
        tick();
        applyStimulus(1, 32'h8000_0000, 32'h2, 32, 1, 32'h8D);
        checkOutput(1, 34, "reduce_x32");
        tick();

        // Backpressure: a second request waits behind an unconsumed result.
        applyStimulus(0, 32'h3, 32'h3, 32, 0, 32'h0);
        waitValid(0, lat);
        drive(0, 1'b1, 32'h0001_2345, 32'h0000_0F0F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", 63'(getOv(0)), 63'(1));
            check("bp_y_held", getY(0), 63'h5);
            check("bp_in_ready", 63'(getIr(0)), 63'(0));
        end
        setOready(0, 1'b1);
        tick();
        setOready(0, 1'b0);
        discard = sb.pop_front();
        check("bp_drop", 63'(getOv(0)), 63'(0));
        check("bp_idle_ready", 63'(getIr(0)), 63'(1));
        check("bp_not_taken", 63'(getBusy(0)), 63'(0));
        sb.push_back(refMul(32'h0001_2345, 32'h0000_0F0F, 32, 0, 32'h0));
        tick();
        drive(0, 1'b0, 32'h0, 32'h0);
        check("bp_second_taken", 63'(getBusy(0)), 63'(1));
        checkOutput(0, 3, "bp_second");
        tick();

        // Reset while the second sub-product is being formed.
        applyStimulus(0, 32'hDEAD_BEEF, 32'h1234_5679, 32, 0, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        discard = sb.pop_front();
        check("midrst_busy", 63'(getBusy(0)), 63'(0));
        check("midrst_valid", 63'(getOv(0)), 63'(0));
        check("midrst_y", getY(0), 63'(0));
        check("midrst_ready", 63'(getIr(0)), 63'(1));
        applyStimulus(0, 32'hCAFE_F00D, 32'h8765_4321, 32, 0, 32'h0);
        checkOutput(0, 3, "after_rst");

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 250; i++) begin
                mask = (d == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
                ra = $urandom() & mask;
                rb = $urandom() & mask;
                if (i == 0) ra = 32'h0;
                if (i == 1) rb = 32'h0;
                applyStimulus(d, ra, rb, (d == 2) ? 8 : 32, (d == 0) ? 0 : 1,
                              (d == 2) ? 32'h1B : 32'h8D);
                checkOutput(d, (d == 0) ? 3 : ((d == 1) ? 34 : 10), "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
